instruction_fetch_stage: RTL and testbench
==========================================

// Module: instruction_fetch_stage
// PURPOSE
// - IF stage of the MIPS core: holds the PC and reads one 32-bit word per cycle from the byte-addressed instruction memory.
// - Registers the word into the IF/ID pipeline register feeding decode.
// - Supports stall, branch/jump redirect with flush, and a sticky halt after consecutive NOP fetches.
// PARAMETERS
// - ADDR_BITS  8   byte-address bits used to index instruction_mem (2**ADDR_BITS bytes)
// - RESET_PC   0   PC value loaded on reset
// - HALT_NOPS  3   consecutive fetched NOP words that set halted; 0 disables halt
// PORTS
// - clk               in   1              single clock, all state on rising edge
// - reset             in   1              synchronous, active-high
// - instruction_mem   in   8 x 2**ADDR_BITS   unpacked byte array, instruction memory image
// - stall             in   1              hazard unit: hold PC and IF/ID
// - redirect          in   1              branch taken / jump from a later stage
// - redirect_target   in   32             new PC when redirect=1
// - pc                out  32             current fetch PC
// - next_instruction  out  32             combinational word at pc
// - if_id_instruction out  32             registered instruction to decode
// - if_id_pc_plus4    out  32             registered PC+4 of that instruction
// - if_id_valid       out  1              IF/ID holds a real fetched instruction
// - halted            out  1              sticky halt flag
// BEHAVIOUR
// - Fetch word: next_instruction = {mem[a+3], mem[a+2], mem[a+1], mem[a]}, where a = {pc[ADDR_BITS-1:2], 2'b00}.
//   - Index wraps modulo 2**ADDR_BITS.
//   - a+3 never crosses the array end because a is aligned.
// - Reset (sync, clk edge with reset=1) sets:
//   - pc=RESET_PC
//   - if_id_instruction=0, if_id_pc_plus4=0, if_id_valid=0
//   - halted=0, nop_count=0
// - Per-edge priority: reset > redirect > halted > stall > normal.
// - Redirect:
//   - pc <= {redirect_target[31:2], 2'b00}; target bits [1:0] are ignored.
//   - IF/ID flushed: instruction=0, pc_plus4=0, valid=0.
//   - nop_count <= 0.
//   - Wins over a simultaneous stall.
//   - Ignored once halted.
// - Halted: pc holds; IF/ID loads NOP with valid=0; halted stays 1 until reset.
// - Stall: pc, IF/ID and nop_count all hold.
// - Normal:
//   - IF/ID <= {next_instruction, pc+4, valid=1}.
//   - pc <= pc+4; 32-bit wrap, 0xFFFFFFFC -> 0x00000000.
// - Latency: a word at pc appears on if_id_instruction one edge later.
// - NOP counting (normal cycles only):
//   - next_instruction==0 increments nop_count, saturating at HALT_NOPS; a non-zero word clears it.
//   - The edge on which nop_count reaches HALT_NOPS also sets halted, and that third NOP still enters IF/ID with valid=1.
//   - nop_count width is $clog2(HALT_NOPS+1), minimum 1.
// - Reset asserted mid-stall, mid-redirect or while halted: the reset values apply on that same edge.
// STRUCTURE
// - mips_pkg holds: WORD_W=32, MIPS_NOP=32'h0, localparam PC_STEP=4, and typedef if_id_t {instruction, pc_plus4, valid}.
// - One sub-module, if_id_register: takes clk, reset, stall, flush and d (if_id_t), and outputs q (if_id_t).
// - PC, halt logic and fetch mux live in the top module.
// TESTING
// - T1 reset: mem[3:0]={20,0a,00,0a}, hold reset for 2 edges -> pc=0, if_id_valid=0, halted=0, next_instruction=200a000a.
// - T2 sequential fetch: release reset, mem[7:4]={20,0c,00,0b} -> edge1: if_id_instruction=200a000a, pc_plus4=4, pc=4; edge2: 200c000b, pc_plus4=8.
// - T3 stall: stall=1 for 2 edges at pc=8 -> pc=8 and IF/ID unchanged; after stall drops, the next edge gives pc=C.
// - T4 redirect+stall: at pc=C drive stall=1, redirect=1, target=0x13 -> pc=0x10, if_id_valid=0, if_id_instruction=0.
// - T5 halt: words 0x8..0x10 all zero, fetch from 0x8 -> after 3 edges halted=1, pc=0x14 and frozen; redirect afterwards is ignored; reset clears halted.
// - T6 wrap: mem[255:252]={01,6a,58,20}, redirect to 0xFC -> next_instruction=016a5820; one edge later pc_plus4=0x100, and next_instruction reads mem[3:0].

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS core types and constants.
// Holds the word width, NOP encoding, PC step and IF/ID bundle type.
package mips_pkg;

  localparam int WORD_W = 32;

  localparam logic [WORD_W-1:0] MIPS_NOP = 32'h0;

  localparam logic [WORD_W-1:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic [WORD_W-1:0] instruction;
    logic [WORD_W-1:0] pc_plus4;
    logic              valid;
  } if_id_t;

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register.
// Ports: clk, reset, stall (hold), flush (load bubble), d in, q out.
module if_id_register
  import mips_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   stall,
  input  logic   flush,
  input  if_id_t d,
  output if_id_t q
);

  // A bubble is an all-zero bundle: NOP, pc_plus4=0, valid=0.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      q <= '0;
    end else if (!stall) begin
      q <= d;
    end
  end

endmodule

// File: rtl/instruction_fetch_stage.sv
// IF stage: PC register, word fetch from byte memory, NOP halt detect.
// Ports: clk, reset, instruction_mem, stall, redirect(+target) in;
// pc, next_instruction, if_id_* and halted out.
module instruction_fetch_stage
  import mips_pkg::*;
#(
  parameter int              ADDR_BITS = 8,
  parameter logic [31:0]     RESET_PC  = 32'h0,
  parameter int              HALT_NOPS = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  instruction_mem [2**ADDR_BITS],
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic [31:0] pc,
  output logic [31:0] next_instruction,
  output logic [31:0] if_id_instruction,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic        halted
);

  localparam int NC_W =
    (HALT_NOPS > 0) ? $clog2(HALT_NOPS + 1) : 1;

  localparam logic [NC_W-1:0] NOP_MAX =
    NC_W'(HALT_NOPS);

  logic [NC_W-1:0]      nop_count;
  logic [ADDR_BITS-3:0] word_idx;
  logic [31:0]          pc_plus4;
  logic                 take_redirect;
  if_id_t               d;
  if_id_t               q;

  assign word_idx = pc[ADDR_BITS-1:2];
  assign pc_plus4 = pc + PC_STEP;

  // Little-endian word; aligned index so +3 never wraps.
  assign next_instruction = {
    instruction_mem[{word_idx, 2'd3}],
    instruction_mem[{word_idx, 2'd2}],
    instruction_mem[{word_idx, 2'd1}],
    instruction_mem[{word_idx, 2'd0}]
  };

  assign take_redirect = redirect && !halted;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc        <= RESET_PC;
      halted    <= 1'b0;
      nop_count <= '0;
    end else if (take_redirect) begin
      pc        <= redirect_target & ~32'h3;
      nop_count <= '0;
    end else if (!halted && !stall) begin
      pc <= pc_plus4;
      if (next_instruction == MIPS_NOP) begin
        if (HALT_NOPS != 0 && nop_count != NOP_MAX) begin
          nop_count <= nop_count + NC_W'(1);
          if (nop_count == NOP_MAX - NC_W'(1))
            halted <= 1'b1;
        end
      end else begin
        nop_count <= '0;
      end
    end
  end

  assign d = '{
    instruction: next_instruction,
    pc_plus4:    pc_plus4,
    valid:       1'b1
  };

  // Halted also feeds bubbles, overriding stall.
  if_id_register u_if_id (
    .clk   (clk),
    .reset (reset),
    .stall (stall),
    .flush (take_redirect || halted),
    .d     (d),
    .q     (q)
  );

  assign if_id_instruction = q.instruction;
  assign if_id_pc_plus4    = q.pc_plus4;
  assign if_id_valid       = q.valid;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Self-checking bench for instruction_fetch_stage.
// Table rows hold stimulus and hand-derived expected state after the edge.
module tb_instruction_fetch_stage;

  typedef struct {
    logic        rst;
    logic        stl;
    logic        rdr;
    logic [31:0] tgt;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    logic [31:0] e_pc4;
    logic        e_valid;
    logic        e_halt;
    logic [31:0] e_next;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  mem [256];
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_target;
  logic [31:0] pc;
  logic [31:0] next_instruction;
  logic [31:0] if_id_instruction;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_valid;
  logic        halted;

  int   n_vec  = 0;
  int   n_miss = 0;
  vec_t exp_q[$];
  vec_t tbl[$];

  always #5 clk = ~clk;

  instruction_fetch_stage dut (
    .clk               (clk),
    .reset             (reset),
    .instruction_mem   (mem),
    .stall             (stall),
    .redirect          (redirect),
    .redirect_target   (redirect_target),
    .pc                (pc),
    .next_instruction  (next_instruction),
    .if_id_instruction (if_id_instruction),
    .if_id_pc_plus4    (if_id_pc_plus4),
    .if_id_valid       (if_id_valid),
    .halted            (halted)
  );

  function automatic vec_t mk(
    logic r, logic s, logic d, logic [31:0] t,
    logic [31:0] p, logic [31:0] i, logic [31:0] p4,
    logic v, logic h, logic [31:0] nx);
    vec_t x;
    x.rst = r; x.stl = s; x.rdr = d; x.tgt = t;
    x.e_pc = p; x.e_inst = i; x.e_pc4 = p4;
    x.e_valid = v; x.e_halt = h; x.e_next = nx;
    return x;
  endfunction

  task automatic chk(string nm, int row,
                     logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s row %0d: got %h want %h",
               nm, row, act, exp);
    end
  endtask

  task automatic apply(int row, vec_t v);
    vec_t e;
    reset           = v.rst;
    stall           = v.stl;
    redirect        = v.rdr;
    redirect_target = v.tgt;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("pc",     row, pc,                e.e_pc);
    chk("inst",   row, if_id_instruction, e.e_inst);
    chk("pc4",    row, if_id_pc_plus4,    e.e_pc4);
    chk("valid",  row, 32'(if_id_valid),  32'(e.e_valid));
    chk("halted", row, 32'(halted),       32'(e.e_halt));
    chk("next",   row, next_instruction,  e.e_next);
  endtask

  localparam logic [31:0] W0 = 32'h200a000a;
  localparam logic [31:0] W1 = 32'h200c000b;
  localparam logic [31:0] WE = 32'h016a5820;

  initial begin
    foreach (mem[i]) mem[i] = 8'h00;
    mem[0] = 8'h0a; mem[1] = 8'h00;
    mem[2] = 8'h0a; mem[3] = 8'h20;
    mem[4] = 8'h0b; mem[5] = 8'h00;
    mem[6] = 8'h0c; mem[7] = 8'h20;
    mem[252] = 8'h20; mem[253] = 8'h58;
    mem[254] = 8'h6a; mem[255] = 8'h01;
    reset = 1'b1; stall = 1'b0;
    redirect = 1'b0; redirect_target = '0;

    // reset, sequential fetch, stall, redirect+stall
    tbl.push_back(mk(1,0,0,0,   0,0,0,0,0, W0));
    tbl.push_back(mk(1,0,0,0,   0,0,0,0,0, W0));
    tbl.push_back(mk(0,0,0,0,   4,W0,4,1,0, W1));
    tbl.push_back(mk(0,0,0,0,   8,W1,8,1,0, 0));
    tbl.push_back(mk(0,1,0,0,   8,W1,8,1,0, 0));
    tbl.push_back(mk(0,1,0,0,   8,W1,8,1,0, 0));
    tbl.push_back(mk(0,0,0,0,   'hC,0,'hC,1,0, 0));
    tbl.push_back(mk(0,1,1,'h13,'h10,0,0,0,0, 0));
    // halt after three NOPs, then frozen
    tbl.push_back(mk(0,0,1,8,   8,0,0,0,0, 0));
    tbl.push_back(mk(0,0,0,0,   'hC,0,'hC,1,0, 0));
    tbl.push_back(mk(0,0,0,0,   'h10,0,'h10,1,0, 0));
    tbl.push_back(mk(0,0,0,0,   'h14,0,'h14,1,1, 0));
    tbl.push_back(mk(0,0,0,0,   'h14,0,0,0,1, 0));
    tbl.push_back(mk(0,0,1,'h40,'h14,0,0,0,1, 0));
    tbl.push_back(mk(0,1,0,0,   'h14,0,0,0,1, 0));
    tbl.push_back(mk(1,0,0,0,   0,0,0,0,0, W0));
    // memory index wrap
    tbl.push_back(mk(0,0,1,'hFC,'hFC,0,0,0,0, WE));
    tbl.push_back(mk(0,0,0,0,   'h100,WE,'h100,1,0, W0));
    tbl.push_back(mk(0,0,0,0,   'h104,W0,'h104,1,0, W1));
    tbl.push_back(mk(1,1,1,'h80,0,0,0,0,0, W0));

    foreach (tbl[i]) apply(i, tbl[i]);

    // non-zero word clears the NOP run
    apply(100, mk(0,0,1,'hF4,'hF4,0,0,0,0, 0));
    apply(101, mk(0,0,0,0,'hF8,0,'hF8,1,0, 0));
    apply(102, mk(0,0,0,0,'hFC,0,'hFC,1,0, WE));
    apply(103, mk(0,0,0,0,'h100,WE,'h100,1,0, W0));
    apply(104, mk(0,0,0,0,'h104,W0,'h104,1,0, W1));
    apply(105, mk(0,0,0,0,'h108,W1,'h108,1,0, 0));
    apply(106, mk(0,0,0,0,'h10C,0,'h10C,1,0, 0));
    apply(107, mk(0,0,0,0,'h110,0,'h110,1,0, 0));
    apply(108, mk(0,0,0,0,'h114,0,'h114,1,1, 0));

    // reset while halted, then 32-bit PC wrap
    apply(200, mk(1,0,0,0,0,0,0,0,0, W0));
    apply(201, mk(0,0,1,32'hFFFF_FFFF,
                  32'hFFFF_FFFC,0,0,0,0, WE));
    apply(202, mk(0,0,0,0,0,WE,0,1,0, W0));

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_miss);
    $finish;
  end

endmodule
